hazard_ctrl: RTL and testbench



---
 rtl/hazard_ctrl_pkg.sv | 28 ++
 rtl/hazard_ctrl_if.sv | 55 +++++
 rtl/hazard_match.sv | 49 ++++
 rtl/hazard_ctrl.sv | 167 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg
// Shared definitions for the pipeline hazard controller: forward-select
// encoding, default result-ready stages for ALU and load producers, the
// redirect-pending state type and a helper that sizes the forward select.
// Ports: none (package).
package hazard_ctrl_pkg;

  // Forward select value meaning "take the register file value".
  localparam int FSEL_REGFILE = 0;

  // Stage index at which a result is sitting in that stage's pipeline
  // register: ALU results leave EX one stage later, loads one more.
  localparam int DEF_ALU_RDY  = 1;
  localparam int DEF_LOAD_RDY = 2;

  // A redirect that arrives while EX is frozen is remembered until the
  // freeze lifts, then turned into a flush.
  typedef enum logic {
    REDIR_IDLE = 1'b0,
    REDIR_PEND = 1'b1
  } redir_state_e;

  // Forward select width: enough bits to name any tracked stage, never 0.
  function automatic int fsel_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if
// Bundles the ID/EX side signals seen by the hazard controller.
// master: pipeline side, drives the hc_i_* signals and reads hc_o_*.
// slave : hazard controller, reads hc_i_* and drives hc_o_*.
// Signals:
//   hc_i_id_valid, hc_i_id_rs/rt, hc_i_id_use_rs/rt, hc_i_id_regwr,
//   hc_i_id_rd, hc_i_id_load : instruction currently in ID
//   hc_i_ex_busy             : multi-cycle EX unit not finished
//   hc_i_redirect            : EX resolved a taken branch/jump
//   hc_o_stall/flush/freeze  : pipeline control
//   hc_o_fwd_rs/rt           : EX operand forward selects
//   hc_o_stall_cnt           : saturating stall + freeze cycle count
interface hazard_ctrl_if
  import hazard_ctrl_pkg::*;
#(
  parameter int AWIDTH    = 5,
  parameter int DEPTH     = 3,
  parameter int CNT_WIDTH = 16,
  parameter int FSEL_W    = fsel_width(DEPTH)
);

  logic                 hc_i_id_valid;
  logic [AWIDTH-1:0]    hc_i_id_rs;
  logic [AWIDTH-1:0]    hc_i_id_rt;
  logic                 hc_i_id_use_rs;
  logic                 hc_i_id_use_rt;
  logic                 hc_i_id_regwr;
  logic [AWIDTH-1:0]    hc_i_id_rd;
  logic                 hc_i_id_load;
  logic                 hc_i_ex_busy;
  logic                 hc_i_redirect;
  logic                 hc_o_stall;
  logic                 hc_o_flush;
  logic                 hc_o_freeze;
  logic [FSEL_W-1:0]    hc_o_fwd_rs;
  logic [FSEL_W-1:0]    hc_o_fwd_rt;
  logic [CNT_WIDTH-1:0] hc_o_stall_cnt;

  modport master (
    output hc_i_id_valid, hc_i_id_rs, hc_i_id_rt, hc_i_id_use_rs,
           hc_i_id_use_rt, hc_i_id_regwr, hc_i_id_rd, hc_i_id_load,
           hc_i_ex_busy, hc_i_redirect,
    input  hc_o_stall, hc_o_flush, hc_o_freeze, hc_o_fwd_rs, hc_o_fwd_rt,
           hc_o_stall_cnt
  );

  modport slave (
    input  hc_i_id_valid, hc_i_id_rs, hc_i_id_rt, hc_i_id_use_rs,
           hc_i_id_use_rt, hc_i_id_regwr, hc_i_id_rd, hc_i_id_load,
           hc_i_ex_busy, hc_i_redirect,
    output hc_o_stall, hc_o_flush, hc_o_freeze, hc_o_fwd_rs, hc_o_fwd_rt,
           hc_o_stall_cnt
  );

endinterface

// File: rtl/hazard_match.sv
// hazard_match
// Compares one source register address against the tracked in-flight
// producers and reports the youngest (lowest stage index) match.
// Ports:
//   src       in  source register address
//   use_src   in  source is actually read (already qualified by valid)
//   prod      in  per-stage producer flag (valid & regwr & rd != 0)
//   rd        in  per-stage destination address
//   rdy       in  per-stage stage index at which the result is available
//   hit_idx   out stage index of the youngest matching producer
//   hit       out some producer at stage >= MIN_STAGE matches
//   not_ready out youngest match will not have its result in time for a
//                 consumer entering EX next cycle
module hazard_match
  import hazard_ctrl_pkg::*;
#(
  parameter int AWIDTH    = 5,
  parameter int DEPTH     = 3,
  parameter int FSEL_W    = fsel_width(DEPTH),
  parameter int MIN_STAGE = 0
) (
  input  logic [AWIDTH-1:0]             src,
  input  logic                          use_src,
  input  logic [DEPTH-1:0]              prod,
  input  logic [DEPTH-1:0][AWIDTH-1:0]  rd,
  input  logic [DEPTH-1:0][FSEL_W-1:0]  rdy,
  output logic [FSEL_W-1:0]             hit_idx,
  output logic                          hit,
  output logic                          not_ready
);

  // Scan from oldest to youngest so the youngest match is the last one
  // written. $0 is hard-wired and never creates a dependency.
  always_comb begin
    hit_idx   = FSEL_W'(FSEL_REGFILE);
    hit       = 1'b0;
    not_ready = 1'b0;
    if (use_src && (src != '0)) begin
      for (int k = DEPTH - 1; k >= MIN_STAGE; k--) begin
        if (prod[k] && (rd[k] == src)) begin
          hit       = 1'b1;
          hit_idx   = FSEL_W'(k);
          not_ready = ((k + 1) < int'(rdy[k]));
        end
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Pipeline hazard controller. Tracks destination metadata of every
// in-flight instruction from EX (stage 0) to WB (stage DEPTH-1) and
// derives forward selects, load-use / not-ready stalls, redirect flushes
// and the multi-cycle EX freeze.
// Ports:
//   hc_clk  in  clock
//   hc_rst  in  synchronous active-high reset
//   bus     hazard_ctrl_if.slave (ID inputs, EX busy/redirect, controls)
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int AWIDTH    = 5,
  parameter int DEPTH     = 3,
  parameter int ALU_RDY   = DEF_ALU_RDY,
  parameter int LOAD_RDY  = DEF_LOAD_RDY,
  parameter int CNT_WIDTH = 16,
  parameter int FSEL_W    = fsel_width(DEPTH)
) (
  input logic         hc_clk,
  input logic         hc_rst,
  hazard_ctrl_if.slave bus
);

  logic [DEPTH-1:0]              e_valid;
  logic [DEPTH-1:0]              e_regwr;
  logic [DEPTH-1:0][AWIDTH-1:0]  e_rd;
  logic [DEPTH-1:0][FSEL_W-1:0]  e_rdy;
  logic [DEPTH-1:0]              e_prod;

  logic [AWIDTH-1:0]             s0_rs;
  logic [AWIDTH-1:0]             s0_rt;
  logic                          s0_use_rs;
  logic                          s0_use_rt;

  redir_state_e                  redir_q;
  redir_state_e                  redir_d;
  logic [CNT_WIDTH-1:0]          stall_cnt_q;

  logic                          busy;
  logic                          flush;
  logic                          stall;
  logic                          issue;

  logic [FSEL_W-1:0]             id_rs_idx, id_rt_idx, ex_rs_idx, ex_rt_idx;
  logic                          id_rs_hit, id_rt_hit, ex_rs_hit, ex_rt_hit;
  logic                          id_rs_nr, id_rt_nr, ex_rs_nr, ex_rt_nr;
  logic                          unused_match;

  // An entry only counts as a producer when it really writes a non-zero
  // register.
  always_comb begin
    e_prod = '0;
    for (int k = 0; k < DEPTH; k++) begin
      e_prod[k] = e_valid[k] & e_regwr[k] & (e_rd[k] != '0);
    end
  end

  // Stall lookups for the instruction in ID: any stage may hold the
  // producer, including the one currently in EX.
  hazard_match #(.AWIDTH(AWIDTH), .DEPTH(DEPTH), .FSEL_W(FSEL_W), .MIN_STAGE(0))
    u_id_rs (
      .src(bus.hc_i_id_rs), .use_src(bus.hc_i_id_valid & bus.hc_i_id_use_rs),
      .prod(e_prod), .rd(e_rd), .rdy(e_rdy),
      .hit_idx(id_rs_idx), .hit(id_rs_hit), .not_ready(id_rs_nr));

  hazard_match #(.AWIDTH(AWIDTH), .DEPTH(DEPTH), .FSEL_W(FSEL_W), .MIN_STAGE(0))
    u_id_rt (
      .src(bus.hc_i_id_rt), .use_src(bus.hc_i_id_valid & bus.hc_i_id_use_rt),
      .prod(e_prod), .rd(e_rd), .rdy(e_rdy),
      .hit_idx(id_rt_idx), .hit(id_rt_hit), .not_ready(id_rt_nr));

  // Forward lookups for the instruction in EX: only older stages can
  // supply its operands.
  hazard_match #(.AWIDTH(AWIDTH), .DEPTH(DEPTH), .FSEL_W(FSEL_W), .MIN_STAGE(1))
    u_ex_rs (
      .src(s0_rs), .use_src(e_valid[0] & s0_use_rs),
      .prod(e_prod), .rd(e_rd), .rdy(e_rdy),
      .hit_idx(ex_rs_idx), .hit(ex_rs_hit), .not_ready(ex_rs_nr));

  hazard_match #(.AWIDTH(AWIDTH), .DEPTH(DEPTH), .FSEL_W(FSEL_W), .MIN_STAGE(1))
    u_ex_rt (
      .src(s0_rt), .use_src(e_valid[0] & s0_use_rt),
      .prod(e_prod), .rd(e_rd), .rdy(e_rdy),
      .hit_idx(ex_rt_idx), .hit(ex_rt_hit), .not_ready(ex_rt_nr));

  // The stall lookups only need the ready verdict and the forward lookups
  // only need the stage index; the remaining outputs are collected here.
  assign unused_match = &{1'b0, id_rs_idx, id_rt_idx, id_rs_hit, id_rt_hit,
                          ex_rs_nr, ex_rt_nr};

  // Control precedence: freeze beats redirect, redirect beats stall.
  always_comb begin
    busy  = bus.hc_i_ex_busy;
    flush = ~busy & (bus.hc_i_redirect | (redir_q == REDIR_PEND));
    stall = (id_rs_nr | id_rt_nr) & ~busy & ~flush;
    issue = bus.hc_i_id_valid & ~stall & ~flush & ~busy;
  end

  assign bus.hc_o_stall     = stall;
  assign bus.hc_o_flush     = flush;
  assign bus.hc_o_freeze    = busy;
  assign bus.hc_o_fwd_rs    = ex_rs_hit ? ex_rs_idx : FSEL_W'(FSEL_REGFILE);
  assign bus.hc_o_fwd_rt    = ex_rt_hit ? ex_rt_idx : FSEL_W'(FSEL_REGFILE);
  assign bus.hc_o_stall_cnt = stall_cnt_q;

  // Redirect-pending state: a redirect seen while frozen is parked until
  // the first unfrozen cycle, where flush fires and the state clears.
  always_comb begin
    redir_d = redir_q;
    case (redir_q)
      REDIR_IDLE: if (busy && bus.hc_i_redirect) redir_d = REDIR_PEND;
      REDIR_PEND: if (!busy)                     redir_d = REDIR_IDLE;
      default:                                   redir_d = REDIR_IDLE;
    endcase
  end

  always_ff @(posedge hc_clk) begin
    if (hc_rst) redir_q <= REDIR_IDLE;
    else        redir_q <= redir_d;
  end

  // Entry shift register. Normally everything moves up one stage and
  // stage 0 takes the ID instruction or a bubble. While frozen, stage 0
  // keeps the busy instruction and the bubble is injected at stage 1.
  always_ff @(posedge hc_clk) begin
    if (hc_rst) begin
      e_valid   <= '0;
      e_regwr   <= '0;
      e_rd      <= '0;
      e_rdy     <= '0;
      s0_rs     <= '0;
      s0_rt     <= '0;
      s0_use_rs <= 1'b0;
      s0_use_rt <= 1'b0;
    end else begin
      for (int k = 1; k < DEPTH; k++) begin
        e_valid[k] <= e_valid[k-1];
        e_regwr[k] <= e_regwr[k-1];
        e_rd[k]    <= e_rd[k-1];
        e_rdy[k]   <= e_rdy[k-1];
      end
      if (busy) begin
        e_valid[1] <= 1'b0;
      end else begin
        e_valid[0] <= issue;
        e_regwr[0] <= bus.hc_i_id_regwr;
        e_rd[0]    <= bus.hc_i_id_rd;
        e_rdy[0]   <= bus.hc_i_id_load ? FSEL_W'(LOAD_RDY) : FSEL_W'(ALU_RDY);
        s0_rs      <= bus.hc_i_id_rs;
        s0_rt      <= bus.hc_i_id_rt;
        s0_use_rs  <= bus.hc_i_id_use_rs;
        s0_use_rt  <= bus.hc_i_id_use_rt;
      end
    end
  end

  // Saturating count of cycles lost to stalls and freezes.
  always_ff @(posedge hc_clk) begin
    if (hc_rst) begin
      stall_cnt_q <= '0;
    end else if ((stall || busy) && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
// Directed testbench for hazard_ctrl with the default configuration
// (DEPTH=3, ALU_RDY=1, LOAD_RDY=2). Inputs change 1 time unit after the
// rising edge; outputs are compared on the falling edge.
module tb_hazard_ctrl;

  logic hc_clk;
  logic hc_rst;
  int   total;
  int   bad;

  hazard_ctrl_if #(.AWIDTH(5), .DEPTH(3), .CNT_WIDTH(16)) bus ();

  hazard_ctrl #(
    .AWIDTH(5), .DEPTH(3), .ALU_RDY(1), .LOAD_RDY(2), .CNT_WIDTH(16)
  ) dut (
    .hc_clk(hc_clk),
    .hc_rst(hc_rst),
    .bus(bus)
  );

  initial hc_clk = 1'b0;
  always #5 hc_clk = ~hc_clk;

  task automatic tick();
    @(posedge hc_clk);
    #1;
  endtask

  task automatic sample();
    @(negedge hc_clk);
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt, input logic wr,
                          input logic [4:0] rd, input logic ld);
    bus.hc_i_id_valid  = v;
    bus.hc_i_id_rs     = rs;
    bus.hc_i_id_rt     = rt;
    bus.hc_i_id_use_rs = urs;
    bus.hc_i_id_use_rt = urt;
    bus.hc_i_id_regwr  = wr;
    bus.hc_i_id_rd     = rd;
    bus.hc_i_id_load   = ld;
  endtask

  task automatic idle();
    drive_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    bus.hc_i_ex_busy  = 1'b0;
    bus.hc_i_redirect = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    hc_rst = 1'b1;
    tick();
    hc_rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    drive_id(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0);
    sample();
    total++; if (bus.hc_o_stall !== 1'b0) begin bad++; $display("[TB] FAIL rst_stall got=%0d exp=0", bus.hc_o_stall); end
    total++; if (bus.hc_o_flush !== 1'b0) begin bad++; $display("[TB] FAIL rst_flush got=%0d exp=0", bus.hc_o_flush); end
    total++; if (bus.hc_o_freeze !== 1'b0) begin bad++; $display("[TB] FAIL rst_freeze got=%0d exp=0", bus.hc_o_freeze); end
    total++; if (bus.hc_o_fwd_rs !== 2'd0) begin bad++; $display("[TB] FAIL rst_fwd_rs got=%0d exp=0", bus.hc_o_fwd_rs); end
    total++; if (bus.hc_o_fwd_rt !== 2'd0) begin bad++; $display("[TB] FAIL rst_fwd_rt got=%0d exp=0", bus.hc_o_fwd_rt); end
    total++; if (bus.hc_o_stall_cnt !== 16'd0) begin bad++; $display("[TB] FAIL rst_cnt got=%0d exp=0", bus.hc_o_stall_cnt); end
  endtask

  // lw $2 ; add $3,$2,$4
  task automatic test_load_use();
    do_reset();
    drive_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd2, 1'b1);
    sample();
    total++; if (bus.hc_o_stall !== 1'b0) begin bad++; $display("[TB] FAIL lu_lw_stall got=%0d exp=0", bus.hc_o_stall); end
    tick();
    drive_id(1'b1, 5'd2, 5'd4, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0);
    sample();
    total++; if (bus.hc_o_stall !== 1'b1) begin bad++; $display("[TB] FAIL lu_stall got=%0d exp=1", bus.hc_o_stall); end
    tick();
    sample();
    total++; if (bus.hc_o_stall !== 1'b0) begin bad++; $display("[TB] FAIL lu_stall2 got=%0d exp=0", bus.hc_o_stall); end
    total++; if (bus.hc_o_fwd_rs !== 2'd0) begin bad++; $display("[TB] FAIL lu_bubble_fwd got=%0d exp=0", bus.hc_o_fwd_rs); end
    tick();
    idle();
    sample();
    total++; if (bus.hc_o_fwd_rs !== 2'd2) begin bad++; $display("[TB] FAIL lu_fwd_rs got=%0d exp=2", bus.hc_o_fwd_rs); end
    total++; if (bus.hc_o_fwd_rt !== 2'd0) begin bad++; $display("[TB] FAIL lu_fwd_rt got=%0d exp=0", bus.hc_o_fwd_rt); end
    total++; if (bus.hc_o_stall_cnt !== 16'd1) begin bad++; $display("[TB] FAIL lu_cnt got=%0d exp=1", bus.hc_o_stall_cnt); end
  endtask

  // add $2 ; sub $5,$2,$2 ; or $6,$2,$0
  task automatic test_alu_fwd();
    do_reset();
    drive_id(1'b1, 5'd7, 5'd8, 1'b1, 1'b1, 1'b1, 5'd2, 1'b0);
    tick();
    drive_id(1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0);
    sample();
    total++; if (bus.hc_o_stall !== 1'b0) begin bad++; $display("[TB] FAIL alu_sub_stall got=%0d exp=0", bus.hc_o_stall); end
    tick();
    drive_id(1'b1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0);
    sample();
    total++; if (bus.hc_o_stall !== 1'b0) begin bad++; $display("[TB] FAIL alu_or_stall got=%0d exp=0", bus.hc_o_stall); end
    total++; if (bus.hc_o_fwd_rs !== 2'd1) begin bad++; $display("[TB] FAIL alu_sub_fwd_rs got=%0d exp=1", bus.hc_o_fwd_rs); end
    total++; if (bus.hc_o_fwd_rt !== 2'd1) begin bad++; $display("[TB] FAIL alu_sub_fwd_rt got=%0d exp=1", bus.hc_o_fwd_rt); end
    tick();
    idle();
    sample();
    total++; if (bus.hc_o_fwd_rs !== 2'd2) begin bad++; $display("[TB] FAIL alu_or_fwd_rs got=%0d exp=2", bus.hc_o_fwd_rs); end
    total++; if (bus.hc_o_fwd_rt !== 2'd0) begin bad++; $display("[TB] FAIL alu_or_fwd_rt got=%0d exp=0", bus.hc_o_fwd_rt); end
    total++; if (bus.hc_o_stall_cnt !== 16'd0) begin bad++; $display("[TB] FAIL alu_cnt got=%0d exp=0", bus.hc_o_stall_cnt); end
  endtask

  // lw $0 ; reader of $0
  task automatic test_zero_reg();
    do_reset();
    drive_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1);
    tick();
    drive_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0);
    sample();
    total++; if (bus.hc_o_stall !== 1'b0) begin bad++; $display("[TB] FAIL zero_stall got=%0d exp=0", bus.hc_o_stall); end
    tick();
    idle();
    sample();
    total++; if (bus.hc_o_fwd_rs !== 2'd0) begin bad++; $display("[TB] FAIL zero_fwd_rs got=%0d exp=0", bus.hc_o_fwd_rs); end
    total++; if (bus.hc_o_fwd_rt !== 2'd0) begin bad++; $display("[TB] FAIL zero_fwd_rt got=%0d exp=0", bus.hc_o_fwd_rt); end
  endtask

  // add $2 ; add $2 ; reader of $2 -> youngest producer wins
  task automatic test_back_to_back();
    do_reset();
    drive_id(1'b1, 5'd7, 5'd8, 1'b1, 1'b1, 1'b1, 5'd2, 1'b0);
    tick();
    drive_id(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd2, 1'b0);
    tick();
    drive_id(1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 1'b1, 5'd10, 1'b0);
    tick();
    idle();
    sample();
    total++; if (bus.hc_o_fwd_rs !== 2'd1) begin bad++; $display("[TB] FAIL b2b_fwd_rs got=%0d exp=1", bus.hc_o_fwd_rs); end
    total++; if (bus.hc_o_fwd_rt !== 2'd1) begin bad++; $display("[TB] FAIL b2b_fwd_rt got=%0d exp=1", bus.hc_o_fwd_rt); end
  endtask

  // lw $9 in EX, then busy for 3 cycles with redirect on the first
  task automatic test_freeze_redirect();
    do_reset();
    drive_id(1'b1, 5'd1, 5'd1, 1'b0, 1'b0, 1'b1, 5'd9, 1'b1);
    tick();
    drive_id(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd11, 1'b0);
    for (int c = 0; c < 3; c++) begin
      bus.hc_i_ex_busy  = 1'b1;
      bus.hc_i_redirect = (c == 0);
      sample();
      total++; if (bus.hc_o_freeze !== 1'b1) begin bad++; $display("[TB] FAIL frz_freeze%0d got=%0d exp=1", c, bus.hc_o_freeze); end
      total++; if (bus.hc_o_flush !== 1'b0) begin bad++; $display("[TB] FAIL frz_flush%0d got=%0d exp=0", c, bus.hc_o_flush); end
      total++; if (bus.hc_o_stall !== 1'b0) begin bad++; $display("[TB] FAIL frz_stall%0d got=%0d exp=0", c, bus.hc_o_stall); end
      tick();
    end
    bus.hc_i_ex_busy  = 1'b0;
    bus.hc_i_redirect = 1'b0;
    sample();
    total++; if (bus.hc_o_freeze !== 1'b0) begin bad++; $display("[TB] FAIL frz_end_freeze got=%0d exp=0", bus.hc_o_freeze); end
    total++; if (bus.hc_o_flush !== 1'b1) begin bad++; $display("[TB] FAIL frz_end_flush got=%0d exp=1", bus.hc_o_flush); end
    total++; if (bus.hc_o_stall !== 1'b0) begin bad++; $display("[TB] FAIL frz_end_stall got=%0d exp=0", bus.hc_o_stall); end
    total++; if (bus.hc_o_stall_cnt !== 16'd3) begin bad++; $display("[TB] FAIL frz_cnt got=%0d exp=3", bus.hc_o_stall_cnt); end
    tick();
    sample();
    total++; if (bus.hc_o_flush !== 1'b0) begin bad++; $display("[TB] FAIL frz_after_flush got=%0d exp=0", bus.hc_o_flush); end
    total++; if (bus.hc_o_stall !== 1'b0) begin bad++; $display("[TB] FAIL frz_after_stall got=%0d exp=0", bus.hc_o_stall); end
    total++; if (bus.hc_o_stall_cnt !== 16'd3) begin bad++; $display("[TB] FAIL frz_after_cnt got=%0d exp=3", bus.hc_o_stall_cnt); end
  endtask

  // lw $2 ; add $3,$2,$4 arriving with a redirect
  task automatic test_redirect_stall();
    do_reset();
    drive_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd2, 1'b1);
    tick();
    drive_id(1'b1, 5'd2, 5'd4, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0);
    bus.hc_i_redirect = 1'b1;
    sample();
    total++; if (bus.hc_o_flush !== 1'b1) begin bad++; $display("[TB] FAIL rs_flush got=%0d exp=1", bus.hc_o_flush); end
    total++; if (bus.hc_o_stall !== 1'b0) begin bad++; $display("[TB] FAIL rs_stall got=%0d exp=0", bus.hc_o_stall); end
    tick();
    idle();
    sample();
    total++; if (bus.hc_o_fwd_rs !== 2'd0) begin bad++; $display("[TB] FAIL rs_not_issued got=%0d exp=0", bus.hc_o_fwd_rs); end
    total++; if (bus.hc_o_flush !== 1'b0) begin bad++; $display("[TB] FAIL rs_flush_clear got=%0d exp=0", bus.hc_o_flush); end
    total++; if (bus.hc_o_stall_cnt !== 16'd0) begin bad++; $display("[TB] FAIL rs_cnt got=%0d exp=0", bus.hc_o_stall_cnt); end
  endtask

  // Reset while frozen with a pending redirect
  task automatic test_reset_mid_freeze();
    do_reset();
    drive_id(1'b1, 5'd1, 5'd0, 1'b0, 1'b0, 1'b1, 5'd4, 1'b1);
    tick();
    drive_id(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd12, 1'b0);
    bus.hc_i_ex_busy  = 1'b1;
    bus.hc_i_redirect = 1'b1;
    tick();
    bus.hc_i_redirect = 1'b0;
    hc_rst = 1'b1;
    tick();
    hc_rst = 1'b0;
    bus.hc_i_ex_busy = 1'b0;
    sample();
    total++; if (bus.hc_o_flush !== 1'b0) begin bad++; $display("[TB] FAIL rmf_flush got=%0d exp=0", bus.hc_o_flush); end
    total++; if (bus.hc_o_freeze !== 1'b0) begin bad++; $display("[TB] FAIL rmf_freeze got=%0d exp=0", bus.hc_o_freeze); end
    total++; if (bus.hc_o_stall !== 1'b0) begin bad++; $display("[TB] FAIL rmf_stall got=%0d exp=0", bus.hc_o_stall); end
    total++; if (bus.hc_o_stall_cnt !== 16'd0) begin bad++; $display("[TB] FAIL rmf_cnt got=%0d exp=0", bus.hc_o_stall_cnt); end
    tick();
    idle();
    sample();
    total++; if (bus.hc_o_flush !== 1'b0) begin bad++; $display("[TB] FAIL rmf_late_flush got=%0d exp=0", bus.hc_o_flush); end
    total++; if (bus.hc_o_fwd_rs !== 2'd0) begin bad++; $display("[TB] FAIL rmf_fwd_rs got=%0d exp=0", bus.hc_o_fwd_rs); end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    hc_rst = 1'b1;
    idle();
    test_reset();
    test_load_use();
    test_alu_fwd();
    test_zero_reg();
    test_back_to_back();
    test_freeze_redirect();
    test_redirect_stall();
    test_reset_mid_freeze();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
